// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serialises one payload word per frame onto a UART line: start bit, DATA_W data
//   bits LSB first, optional even/odd parity bit, then one or two stop bits. Every
//   serial bit lasts CLKS_PER_BIT clocks. A single WCE cycle follows each
//   acceptance, so the line stays high for one extra clock before the start bit.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset; aborts any frame in progress
//   tx_data_i   : payload word, sampled on acceptance
//   tx_valid_i  : request; a frame is accepted when tx_valid_i && tx_ready_o
//   tx_ready_o  : high only in IDLE
//   par_en_i    : 1 inserts a parity bit (sampled on acceptance)
//   par_odd_i   : 1 odd parity, 0 even parity (sampled on acceptance)
//   stop2_i     : 1 sends two stop bits, 0 sends one (sampled on acceptance)
//   tx_o        : serial line, idle high, registered
//   busy_o      : a frame is in progress (state is not IDLE)

module uart_tx_serializer #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              par_en_i,
    input  logic              par_odd_i,
    input  logic              stop2_i,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StWce   = 3'b001,
        StTstrb = 3'b010,
        StTdt   = 3'b011,
        StTparb = 3'b100,
        StTstb1 = 3'b101,
        StTstb2 = 3'b110
    } state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;

    logic              baud_last;

    assign baud_last = (baud_q == BaudLast);

    // State register: all flops, reset has priority over any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
        end
    end

    // Next-state logic. The baud counter wraps to 0 on the same cycle the bit
    // state changes, so each bit state is held for exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
        stop2_d   = stop2_q;

        case (state_q)
            StIdle: begin
                if (tx_valid_i) begin
                    state_d   = StWce;
                    data_d    = tx_data_i;
                    par_en_d  = par_en_i;
                    par_odd_d = par_odd_i;
                    stop2_d   = stop2_i;
                end
            end
            StWce: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = StTstrb;
            end
            StTstrb: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StTdt;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StTdt: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == BitLast) begin
                        bit_d   = '0;
                        state_d = par_en_q ? StTparb : StTstb1;
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StTparb: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StTstb1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StTstb1: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = stop2_q ? StTstb2 : StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StTstb2: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                // Unused encoding: recover to IDLE with the line high.
                state_d = StIdle;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Output logic. tx_d is decoded from the *next* state so the registered line
    // changes on the same edge as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StTstrb: tx_d = 1'b0;
            StTdt:   tx_d = data_q[bit_d];
            StTparb: tx_d = (^data_q) ^ par_odd_q;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = (state_q == StIdle);
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int unsigned DataW = 8;
    localparam int unsigned Cpb   = 4;

    logic             clk;
    logic             rst;
    logic [DataW-1:0] tx_data_i;
    logic             tx_valid_i;
    logic             tx_ready_o;
    logic             par_en_i;
    logic             par_odd_i;
    logic             stop2_i;
    logic             tx_o;
    logic             busy_o;

    int errors;
    int checks;

    uart_tx_serializer #(
        .DATA_W       (DataW),
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .par_en_i   (par_en_i),
        .par_odd_i  (par_odd_i),
        .stop2_i    (stop2_i),
        .tx_o       (tx_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge (sample/drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at the sample point just after the acceptance edge. bits[i] is the
    // i-th serial bit in time order (start bit first). Optionally rewrites
    // tx_data_i at frame cycle chg_cycle to show it has no effect.
    task automatic expect_frame(input logic [11:0] bits, input int nbits, input string name,
                                input int chg_cycle, input logic [7:0] chg_data);
        int cyc;
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b1 || tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s wce: tx=%b busy=%b ready=%b want tx=1 busy=1 ready=0",
                     name, tx_o, busy_o, tx_ready_o);
        end
        cyc = 0;
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < int'(Cpb); c++) begin
                step();
                if (cyc == chg_cycle) tx_data_i = chg_data;
                cyc++;
                checks++;
                if (tx_o !== bits[i] || busy_o !== 1'b1 || tx_ready_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b ready=%b want tx=%b busy=1 ready=0",
                             name, i, c, tx_o, busy_o, tx_ready_o, bits[i]);
                end
            end
        end
        step();
        checks++;
        if (tx_ready_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
            errors++;
            $display("FAIL %s end: ready=%b busy=%b tx=%b want ready=1 busy=0 tx=1",
                     name, tx_ready_o, busy_o, tx_o);
        end
    endtask

    // Present a request at the current sample point and return just after acceptance.
    task automatic accept(input logic [7:0] d, input logic pe, input logic po, input logic s2);
        tx_data_i  = d;
        par_en_i   = pe;
        par_odd_i  = po;
        stop2_i    = s2;
        tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'h00;
        par_en_i   = 1'b0;
        par_odd_i  = 1'b0;
        stop2_i    = 1'b0;
        step();
        step();
        checks++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx=%b ready=%b busy=%b want tx=1 ready=1 busy=0",
                     tx_o, tx_ready_o, busy_o);
        end
        tx_valid_i = 1'b0;
        rst        = 1'b0;
        step();
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: tx=%b busy=%b want tx=1 busy=0", tx_o, busy_o);
        end
    endtask

    task automatic test_even_parity();
        accept(8'hA5, 1'b1, 1'b0, 1'b0);
        // Config changes after acceptance must not alter the frame.
        par_en_i  = 1'b0;
        stop2_i   = 1'b1;
        par_odd_i = 1'b1;
        expect_frame(12'b010101001010, 11, "a5_even", -1, 8'h00);
    endtask

    task automatic test_odd_parity();
        accept(8'hA5, 1'b1, 1'b1, 1'b0);
        expect_frame(12'b011101001010, 11, "a5_odd", 5, 8'h00);
    endtask

    task automatic test_two_stop();
        accept(8'h00, 1'b0, 1'b0, 1'b1);
        expect_frame(12'b011000000000, 11, "00_stop2", -1, 8'h00);
    endtask

    task automatic test_back_to_back();
        tx_data_i  = 8'h3C;
        par_en_i   = 1'b0;
        par_odd_i  = 1'b0;
        stop2_i    = 1'b0;
        tx_valid_i = 1'b1;
        step();
        // valid stays high throughout; data switches to the second word mid-frame.
        expect_frame(12'b001001111000, 10, "b2b_3c", 13, 8'hC3);
        step();
        tx_valid_i = 1'b0;
        expect_frame(12'b001110000110, 10, "b2b_c3", -1, 8'h00);
    endtask

    task automatic test_reset_mid_frame();
        accept(8'h00, 1'b0, 1'b0, 1'b0);
        // WCE + start bit + two data bits + one cycle into the third data bit.
        for (int i = 0; i < int'(Cpb) * 3 + 1; i++) step();
        checks++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: tx=%b busy=%b want tx=0 busy=1", tx_o, busy_o);
        end
        rst        = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = 8'hFF;
        step();
        checks++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort: tx=%b ready=%b busy=%b want tx=1 ready=1 busy=0",
                     tx_o, tx_ready_o, busy_o);
        end
        step();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_valid_ignored: busy=%b want busy=0", busy_o);
        end
        rst        = 1'b0;
        tx_valid_i = 1'b0;
        step();
        accept(8'h96, 1'b1, 1'b0, 1'b0);
        expect_frame(12'b010100101100, 11, "after_abort", -1, 8'h00);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        tx_valid_i = 1'b0;
        tx_data_i  = '0;
        par_en_i   = 1'b0;
        par_odd_i  = 1'b0;
        stop2_i    = 1'b0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), giving the clock cycles per serial bit, minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port tx_data_i, input, DATA_W bits: the payload byte to send.
REQ-006 The block SHALL have port tx_valid_i, input, 1 bit: tx_data_i and the config inputs are valid.
REQ-007 The block SHALL have port tx_ready_o, output, 1 bit: the block can accept a frame.
REQ-008 The block SHALL have port par_en_i, input, 1 bit: 1 inserts a parity bit.
REQ-009 The block SHALL have port par_odd_i, input, 1 bit: 1 selects odd parity, 0 selects even parity.
REQ-010 The block SHALL have port stop2_i, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-011 The block SHALL have port tx_o, output, 1 bit: the serial line, idle high, driven from a register.
REQ-012 The block SHALL have port busy_o, output, 1 bit: a frame is in progress (state is not IDLE).

Function
REQ-013 The block SHALL implement a state machine with states IDLE, WCE, TSTRB, TDT, TPARB, TSTB1 and TSTB2, encoded 3'b000 to 3'b110.
REQ-014 The block SHALL drive tx_ready_o high only in IDLE, and SHALL accept a frame on any cycle where tx_valid_i and tx_ready_o are both high.
REQ-015 On acceptance the block SHALL latch tx_data_i, par_en_i, par_odd_i and stop2_i, and SHALL go to WCE; input changes after acceptance SHALL have no effect on the frame.
REQ-016 WCE SHALL last exactly 1 cycle, clear the baud counter and bit counter, then go to TSTRB.
REQ-017 TSTRB SHALL drive tx_o low for CLKS_PER_BIT cycles.
REQ-018 TDT SHALL send DATA_W bits LSB first, each held for CLKS_PER_BIT cycles; a bit counter from 0 to DATA_W-1 SHALL select the bit.
REQ-019 After TDT the block SHALL go to TPARB if the latched par_en is 1, otherwise to TSTB1.
REQ-020 TPARB SHALL drive the XOR of the latched data, inverted when the latched par_odd is 1, for CLKS_PER_BIT cycles.
REQ-021 TSTB1 SHALL drive tx_o high for CLKS_PER_BIT cycles, then go to TSTB2 if the latched stop2 is 1, otherwise to IDLE.
REQ-022 TSTB2 SHALL drive tx_o high for CLKS_PER_BIT cycles, then go to IDLE.
REQ-023 The baud counter SHALL count from 0 to CLKS_PER_BIT-1 and wrap to 0 on the cycle of each bit-state change, so every bit lasts exactly CLKS_PER_BIT cycles.
REQ-024 tx_o SHALL change on the same clock edge as the state change it belongs to.
REQ-025 Frame length from the acceptance edge to the return to IDLE SHALL be 1 + CLKS_PER_BIT*(1 + DATA_W + par_en + 1 + stop2) cycles.
REQ-026 tx_ready_o SHALL rise in the first cycle after the last stop-bit cycle, so back-to-back frames have no idle gap beyond WCE.
REQ-027 tx_valid_i while busy SHALL be ignored without loss of the current frame; the source SHALL hold the request until it is accepted.
REQ-028 Unused state encodings SHALL go to IDLE with tx_o high on the next edge.

Reset
REQ-029 While rst is high at a clock edge: state IDLE, tx_o 1, tx_ready_o 1, busy_o 0, and all counters and latches cleared.
REQ-030 Reset during a frame SHALL abort the frame, with tx_o high from the next edge; tx_valid_i during reset SHALL be ignored.

Verification (CLKS_PER_BIT=4, DATA_W=8)
REQ-031 0xA5, par_en=1, par_odd=0, stop2=0 -> tx_o per bit 0,1,0,1,0,0,1,0,1,0,1, each 4 cycles; tx_ready_o high again 45 cycles after acceptance.
REQ-032 0xA5, par_en=1, par_odd=1 -> parity bit 1; all other bits as in REQ-031.
REQ-033 0x00, par_en=0, stop2=1 -> tx_o is 0 for 36 cycles then 1 for 8 cycles; busy_o is high for 45 cycles.
REQ-034 tx_valid_i held high with 0x3C then 0xC3 -> two frames with exactly 1 WCE cycle between them; tx_data_i changed mid-frame has no effect on the bits sent.
REQ-035 rst asserted in the 3rd TDT bit -> tx_o=1, tx_ready_o=1 next edge; a new frame accepted after rst falls is sent correctly.
